// File: rtl/axi_tmr_fault_manager.sv
// Fault manager for a bank of TMR voters: per-replica leaky-bucket error counters,
// threshold-driven resync request/ack with a masked hold-off window, and a sticky fatal state.
module axi_tmr_fault_manager #(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 8,
    parameter int THRESH       = 16,
    parameter int HOLDOFF      = 32,
    parameter int DECAY_PERIOD = 1024
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] err_d0,
    input  logic [WIDTH-1:0] err_d1,
    input  logic [WIDTH-1:0] err_d2,
    input  logic             resync_ack,
    input  logic             clr_fatal,
    output logic             resync_req,
    output logic [1:0]       resync_id,
    output logic [2:0]       replica_mask,
    output logic             fatal,
    output logic             uncorr_pulse,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [1:0]       state_dbg
);

    localparam int TW = $clog2(DECAY_PERIOD);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESH);
    localparam logic [TW-1:0]    DECAY_LAST = TW'(DECAY_PERIOD - 1);
    localparam logic [HW-1:0]    HOLD_INIT  = HW'(HOLDOFF - 1);

    // state_dbg encoding: 0 IDLE, 1 REQ, 2 HOLD, 3 FATAL
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FATAL = 2'd3} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt     [3];
    logic [CNT_W-1:0] cnt_nxt [3];
    logic [TW-1:0]    timer;
    logic [HW-1:0]    hold_cnt;

    logic [WIDTH-1:0] u_bits;
    logic             uncorr;
    logic [2:0]       hit;
    logic [2:0]       live_hit;
    logic [2:0]       over_thr;
    logic             any_hit;
    logic             decay;

    assign u_bits   = err_d0 & err_d1 & err_d2;
    assign uncorr   = |u_bits;
    assign hit[0]   = |(err_d0 & ~u_bits);
    assign hit[1]   = |(err_d1 & ~u_bits);
    assign hit[2]   = |(err_d2 & ~u_bits);
    assign live_hit = hit & ~replica_mask;
    assign any_hit  = |live_hit;
    assign decay    = !any_hit && (timer == DECAY_LAST);

    assign err_cnt0  = cnt[0];
    assign err_cnt1  = cnt[1];
    assign err_cnt2  = cnt[2];
    assign state_dbg = state;

    // A hit and a decay step never coincide: any unmasked hit restarts the decay timer.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_nxt[k]  = cnt[k];
            over_thr[k] = (cnt[k] >= THR);
            if (live_hit[k] && cnt[k] != CNT_MAX)
                cnt_nxt[k] = cnt[k] + 1'b1;
            else if (decay && cnt[k] != '0)
                cnt_nxt[k] = cnt[k] - 1'b1;
        end
    end

    // Handshake: resync_req is a valid held high with a stable resync_id until the cycle
    // in which resync_ack (ready) is also high; that cycle is the single transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            resync_req   <= 1'b0;
            resync_id    <= 2'd0;
            replica_mask <= 3'b000;
            fatal        <= 1'b0;
            uncorr_pulse <= 1'b0;
            timer        <= '0;
            hold_cnt     <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            uncorr_pulse <= uncorr;
            if (state != FATAL) begin
                for (int k = 0; k < 3; k++) cnt[k] <= cnt_nxt[k];
                timer <= (any_hit || decay) ? '0 : timer + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (uncorr) begin
                        state <= FATAL;
                        fatal <= 1'b1;
                    end else if (|over_thr) begin
                        resync_req <= 1'b1;
                        state      <= REQ;
                        if (over_thr[0]) begin
                            resync_id    <= 2'd0;
                            replica_mask <= 3'b001;
                        end else if (over_thr[1]) begin
                            resync_id    <= 2'd1;
                            replica_mask <= 3'b010;
                        end else begin
                            resync_id    <= 2'd2;
                            replica_mask <= 3'b100;
                        end
                    end
                end
                REQ: begin
                    if (uncorr) begin
                        state        <= FATAL;
                        fatal        <= 1'b1;
                        resync_req   <= 1'b0;
                        replica_mask <= 3'b000;
                    end else if (resync_ack) begin
                        resync_req <= 1'b0;
                        hold_cnt   <= HOLD_INIT;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (uncorr) begin
                        state        <= FATAL;
                        fatal        <= 1'b1;
                        replica_mask <= 3'b000;
                    end else if (hold_cnt == '0) begin
                        // Resynced replica starts from a clean slate.
                        for (int k = 0; k < 3; k++)
                            if (resync_id == 2'(k)) cnt[k] <= '0;
                        replica_mask <= 3'b000;
                        state        <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                FATAL: begin
                    if (clr_fatal && !uncorr) begin
                        for (int k = 0; k < 3; k++) cnt[k] <= '0;
                        timer <= '0;
                        fatal <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
